ula_sequenciador_8bits: RTL and testbench

Sequencer directly upstream of the 8-bit ALU (ULA_8Bits), which is purely combinational. It accepts one operation request at a time through a valid/ready handshake and drives registered operands and opcode into the ALU. After a programmable settle time it captures the ALU result and flags into output registers and holds them under a second valid/ready handshake. An internal accumulator lets chained operations reuse the previous result as operand A.

---
 rtl/ula_pkg.sv | 24 ++
 rtl/ula_sequenciador_8bits.sv | 149 ++++++++++++++
 tb/tb_ula_sequenciador_8bits.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ula_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, FSM state encoding and
// the reserved-opcode predicate.
package ula_pkg;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_XOR  = 3'b010;
  localparam logic [2:0] OP_NOT  = 3'b011;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_SUB  = 3'b101;
  localparam logic [2:0] OP_RES0 = 3'b110;
  localparam logic [2:0] OP_RES1 = 3'b111;

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,
    EXECUTA   = 2'd1,
    RESULTADO = 2'd2
  } estado_t;

  function automatic logic op_reservada(input logic [2:0] op);
    return (op == OP_RES0) || (op == OP_RES1);
  endfunction

endpackage

// File: rtl/ula_sequenciador_8bits.sv
// Sequencer in front of the combinational 8-bit ALU: registers operands, waits
// LATENCIA_ULA cycles (legal 1..15), captures result/flags and holds them.
module ula_sequenciador_8bits
  import ula_pkg::*;
#(
  parameter int unsigned LATENCIA_ULA = 1,
  parameter logic [7:0]  ACC_RESET    = 8'h00
) (
  input  logic       Clock_in,
  input  logic       Reset_in,
  input  logic       Op_valid_in,
  output logic       Op_ready_out,
  input  logic [7:0] A_dado_in,
  input  logic [7:0] B_dado_in,
  input  logic       C_dado_in,
  input  logic [2:0] Operacao_dado_in,
  input  logic       Acumula_in,
  output logic [7:0] A_ula_out,
  output logic [7:0] B_ula_out,
  output logic       C_ula_out,
  output logic [2:0] Operacao_ula_out,
  input  logic [7:0] Saida_ula_in,
  input  logic [2:0] Flags_ula_in,
  output logic       Res_valid_out,
  input  logic       Res_ready_in,
  output logic [7:0] Resultado_out,
  output logic [2:0] Flags_res_out,
  output logic       Erro_out
);

  localparam logic [3:0] CNT_INIT = 4'(LATENCIA_ULA - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] acc_q, acc_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic       c_q, c_d;
  logic [2:0] op_q, op_d;
  logic [7:0] res_q, res_d;
  logic [2:0] flags_q, flags_d;
  logic       valid_q, valid_d;
  logic       erro_q, erro_d;
  logic       aceita;

  // Ready is masked while reset is held so every output reads 0 during reset.
  assign Op_ready_out = (estado_q == OCIOSO) && !Reset_in;
  assign aceita       = Op_valid_in && Op_ready_out;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case
    // leaves a signal unassigned and no latch is inferred.
    estado_d = estado_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    op_d     = op_q;
    res_d    = res_q;
    flags_d  = flags_q;
    valid_d  = valid_q;
    erro_d   = erro_q;

    case (estado_q)
      OCIOSO: begin
        if (aceita) begin
          if (op_reservada(Operacao_dado_in)) begin
            // ALU-side registers and accumulator are left untouched.
            res_d    = 8'h00;
            flags_d  = 3'b000;
            erro_d   = 1'b1;
            valid_d  = 1'b1;
            estado_d = RESULTADO;
          end else begin
            a_d      = Acumula_in ? acc_q : A_dado_in;
            b_d      = B_dado_in;
            c_d      = C_dado_in;
            op_d     = Operacao_dado_in;
            cnt_d    = CNT_INIT;
            estado_d = EXECUTA;
          end
        end
      end

      EXECUTA: begin
        if (cnt_q == 4'd0) begin
          res_d    = Saida_ula_in;
          acc_d    = Saida_ula_in;
          flags_d  = Flags_ula_in;
          erro_d   = 1'b0;
          valid_d  = 1'b1;
          estado_d = RESULTADO;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESULTADO: begin
        if (Res_ready_in) begin
          valid_d  = 1'b0;
          estado_d = OCIOSO;
        end
      end

      default: estado_d = OCIOSO;
    endcase
  end

  // NOTE: state uses non-blocking assignments so all registers update from
  // the same pre-edge values; these are plain flops, so all are reset.
  always_ff @(posedge Clock_in or posedge Reset_in) begin
    if (Reset_in) begin
      estado_q <= OCIOSO;
      cnt_q    <= 4'd0;
      acc_q    <= ACC_RESET;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      c_q      <= 1'b0;
      op_q     <= 3'b000;
      res_q    <= 8'h00;
      flags_q  <= 3'b000;
      valid_q  <= 1'b0;
      erro_q   <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      op_q     <= op_d;
      res_q    <= res_d;
      flags_q  <= flags_d;
      valid_q  <= valid_d;
      erro_q   <= erro_d;
    end
  end

  assign A_ula_out        = a_q;
  assign B_ula_out        = b_q;
  assign C_ula_out        = c_q;
  assign Operacao_ula_out = op_q;
  assign Resultado_out    = res_q;
  assign Flags_res_out    = flags_q;
  assign Res_valid_out    = valid_q;
  assign Erro_out         = erro_q;

endmodule

// File: tb/tb_ula_sequenciador_8bits.sv
// Bench for ula_sequenciador_8bits: a combinational ALU model sits between the
// ALU-side ports; expected results go through a scoreboard queue.
module tb_ula_sequenciador_8bits;
  import ula_pkg::*;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic       acum;
    logic [7:0] res;
    logic       erro;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    logic [2:0] flags;
    logic       erro;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, op_valid, valid3, res_ready, c_in, acumula;
  logic [7:0] a_in, b_in;
  logic [2:0] op_in;

  logic       ready1, rvalid1, erro1, c_ula1;
  logic [7:0] a_ula1, b_ula1, res1, saida1;
  logic [2:0] op_ula1, flags1, fula1;
  logic       ready3, rvalid3, erro3, c_ula3;
  logic [7:0] a_ula3, b_ula3, res3, saida3;
  logic [2:0] op_ula3, flags3, fula3;

  int   checks   = 0;
  int   failures = 0;
  exp_t sb[$];
  logic [7:0] acc_model, last_a;
  vec_t vecs[13];

  // Stand-in for ULA_8Bits; flags = {carry/borrow, negative, zero}.
  function automatic logic [10:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                            input logic c, input logic [2:0] op);
    logic [8:0] t;
    logic [7:0] r;
    logic       cy;
    t  = 9'd0;
    cy = 1'b0;
    case (op)
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_NOT:  r = ~a;
      OP_ADD:  begin t = {1'b0, a} + {1'b0, b} + {8'd0, c}; r = t[7:0]; cy = t[8]; end
      OP_SUB:  begin t = {1'b0, a} - {1'b0, b} - {8'd0, c}; r = t[7:0]; cy = t[8]; end
      default: r = 8'h00;
    endcase
    return {cy, r[7], (r == 8'h00), r};
  endfunction

  always_comb {fula1, saida1} = alu_model(a_ula1, b_ula1, c_ula1, op_ula1);
  always_comb {fula3, saida3} = alu_model(a_ula3, b_ula3, c_ula3, op_ula3);

  ula_sequenciador_8bits #(.LATENCIA_ULA(1), .ACC_RESET(8'h00)) dut (
    .Clock_in(clk), .Reset_in(rst), .Op_valid_in(op_valid), .Op_ready_out(ready1),
    .A_dado_in(a_in), .B_dado_in(b_in), .C_dado_in(c_in), .Operacao_dado_in(op_in),
    .Acumula_in(acumula), .A_ula_out(a_ula1), .B_ula_out(b_ula1), .C_ula_out(c_ula1),
    .Operacao_ula_out(op_ula1), .Saida_ula_in(saida1), .Flags_ula_in(fula1),
    .Res_valid_out(rvalid1), .Res_ready_in(res_ready), .Resultado_out(res1),
    .Flags_res_out(flags1), .Erro_out(erro1)
  );

  ula_sequenciador_8bits #(.LATENCIA_ULA(3), .ACC_RESET(8'h5A)) dut3 (
    .Clock_in(clk), .Reset_in(rst), .Op_valid_in(valid3), .Op_ready_out(ready3),
    .A_dado_in(a_in), .B_dado_in(b_in), .C_dado_in(c_in), .Operacao_dado_in(op_in),
    .Acumula_in(acumula), .A_ula_out(a_ula3), .B_ula_out(b_ula3), .C_ula_out(c_ula3),
    .Operacao_ula_out(op_ula3), .Saida_ula_in(saida3), .Flags_ula_in(fula3),
    .Res_valid_out(rvalid3), .Res_ready_in(res_ready), .Resultado_out(res3),
    .Flags_res_out(flags3), .Erro_out(erro3)
  );

  // Producer-side protocol: a stalled request must not change.
  logic [20:0] req_prev;
  logic        hold_prev = 1'b0;
  always @(posedge clk) begin
    if (hold_prev && op_valid && ({op_in, a_in, b_in, c_in, acumula} != req_prev)) begin
      failures++;
      $display("FAIL producer_hold: request changed while stalled");
    end
    hold_prev <= op_valid && !ready1;
    req_prev  <= {op_in, a_in, b_in, c_in, acumula};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result is released.
  task automatic run_op(input string nm, input vec_t v);
    exp_t       e;
    logic [7:0] a_eff;
    logic [10:0] m;
    int         n;
    op_in = v.op; a_in = v.a; b_in = v.b; c_in = v.c; acumula = v.acum;
    res_ready = 1'b1;
    op_valid  = 1'b1;
    n = 0;
    while (!ready1 && n < 20) begin @(negedge clk); n++; end
    check({nm, " accept"}, 32'(ready1), 32'd1);
    a_eff   = v.acum ? acc_model : v.a;
    m       = alu_model(a_eff, v.b, v.c, v.op);
    e.res   = v.res;
    e.erro  = v.erro;
    e.flags = v.erro ? 3'b000 : m[10:8];
    @(posedge clk);
    sb.push_back(e);
    @(negedge clk);
    op_valid = 1'b0;
    if (!v.erro) begin
      last_a    = a_eff;
      acc_model = v.res;
    end
    check({nm, " a_ula"}, 32'(a_ula1), 32'(last_a));
    n = 0;
    while (!rvalid1 && n < 20) begin @(negedge clk); n++; end
    check({nm, " latency"}, 32'(n), v.erro ? 32'd0 : 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({nm, " res"},   32'(res1),   32'(e.res));
      check({nm, " flags"}, 32'(flags1), 32'(e.flags));
      check({nm, " erro"},  32'(erro1),  32'(e.erro));
    end
    @(negedge clk);
    check({nm, " handoff"}, 32'({ready1, rvalid1}), 32'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    vecs[0]  = '{OP_ADD,  8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0};
    vecs[1]  = '{OP_ADD,  8'h10, 8'h05, 1'b0, 1'b0, 8'h15, 1'b0};
    vecs[2]  = '{OP_ADD,  8'h00, 8'h03, 1'b0, 1'b1, 8'h18, 1'b0};
    vecs[3]  = '{OP_RES0, 8'hAA, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1};
    vecs[4]  = '{OP_ADD,  8'hEE, 8'h00, 1'b0, 1'b1, 8'h18, 1'b0};
    vecs[5]  = '{OP_SUB,  8'h00, 8'h18, 1'b0, 1'b1, 8'h00, 1'b0};
    vecs[6]  = '{OP_AND,  8'hF0, 8'h3C, 1'b0, 1'b0, 8'h30, 1'b0};
    vecs[7]  = '{OP_OR,   8'h0F, 8'hA0, 1'b0, 1'b0, 8'hAF, 1'b0};
    vecs[8]  = '{OP_XOR,  8'hFF, 8'h0F, 1'b0, 1'b0, 8'hF0, 1'b0};
    vecs[9]  = '{OP_NOT,  8'h55, 8'h00, 1'b0, 1'b0, 8'hAA, 1'b0};
    vecs[10] = '{OP_RES1, 8'h12, 8'h34, 1'b1, 1'b0, 8'h00, 1'b1};
    vecs[11] = '{OP_ADD,  8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0};
    vecs[12] = '{OP_SUB,  8'h00, 8'h01, 1'b0, 1'b0, 8'hFF, 1'b0};

    rst = 1'b1; op_valid = 1'b0; valid3 = 1'b0; res_ready = 1'b0;
    a_in = 8'h00; b_in = 8'h00; c_in = 1'b0; op_in = 3'b000; acumula = 1'b0;
    acc_model = 8'h00; last_a = 8'h00;
    repeat (2) @(negedge clk);
    check("reset outs held", 32'({ready1, rvalid1, erro1, res1, flags1, a_ula1, b_ula1}), 32'd0);
    rst = 1'b0;
    #1;
    check("reset release", 32'({ready1, rvalid1, ready3, rvalid3}), 32'b1010);
    @(negedge clk);

    for (int i = 0; i < 13; i++) run_op($sformatf("v%0d", i), vecs[i]);

    // Back-pressure: result held while a second request waits.
    res_ready = 1'b0;
    op_in = OP_ADD; a_in = 8'h01; b_in = 8'h02; c_in = 1'b0; acumula = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    op_in = OP_XOR; a_in = 8'h33; b_in = 8'h0F;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp hold %0d", i), 32'({ready1, rvalid1, res1}), 32'({1'b0, 1'b1, 8'h03}));
      @(negedge clk);
    end
    res_ready = 1'b1;
    @(negedge clk);
    check("bp ready back", 32'({ready1, rvalid1}), 32'b10);
    @(negedge clk);
    op_valid = 1'b0;
    check("bp 2nd accepted", 32'({a_ula1, op_ula1}), 32'({8'h33, OP_XOR}));
    @(negedge clk);
    check("bp 2nd result", 32'({rvalid1, res1}), 32'({1'b1, 8'h3C}));
    @(negedge clk);
    acc_model = 8'h3C;

    // LATENCIA_ULA=3 instance, accumulator starts at 8'h5A.
    for (int k = 0; k < 2; k++) begin
      logic [7:0] exp_r;
      logic [10:0] m3;
      if (k == 0) begin
        op_in = OP_ADD; a_in = 8'h00; b_in = 8'h01; acumula = 1'b1; exp_r = 8'h5B;
        m3 = alu_model(8'h5A, 8'h01, 1'b0, OP_ADD);
      end else begin
        op_in = OP_AND; a_in = 8'hF0; b_in = 8'h3C; acumula = 1'b0; exp_r = 8'h30;
        m3 = alu_model(8'hF0, 8'h3C, 1'b0, OP_AND);
      end
      c_in = 1'b0; res_ready = 1'b1; valid3 = 1'b1;
      n = 0;
      while (!ready3 && n < 20) begin @(negedge clk); n++; end
      @(posedge clk);
      @(negedge clk);
      valid3 = 1'b0;
      n = 0;
      while (!rvalid3 && n < 20) begin @(negedge clk); n++; end
      check($sformatf("lat3 op%0d edges", k), 32'(n), 32'd3);
      check($sformatf("lat3 op%0d res", k), 32'({flags3, res3, erro3}), 32'({m3[10:8], exp_r, 1'b0}));
      @(negedge clk);
    end

    // Asynchronous reset between edges while in EXECUTA.
    op_in = OP_ADD; a_in = 8'h11; b_in = 8'h22; c_in = 1'b1; acumula = 1'b0; op_valid = 1'b1;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("areset alu side", 32'({a_ula1, b_ula1, c_ula1, op_ula1}), 32'd0);
    check("areset res side", 32'({res1, flags1, erro1, rvalid1, ready1}), 32'd0);
    op_valid = 1'b0;
    #1 rst = 1'b0;
    #2;
    check("areset release", 32'({ready1, rvalid1}), 32'b10);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("areset no pulse %0d", i), 32'({ready1, rvalid1}), 32'b10);
    end
    acc_model = 8'h00;
    last_a    = 8'h00;
    v = '{OP_ADD, 8'h77, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0};
    run_op("acc after reset", v);

    check("scoreboard empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
